// File: rtl/up_pkg.sv
// up_pkg: shared constants for the second-generation micro-controller datapath.
//   - op codes selecting the combinational result (data_out)
//   - bit positions inside the {N,C,Z} flags register
//   - reset-value helpers and the divider state encoding
package up_pkg;

   localparam logic [4:0] OP_ADD    = 5'b00000;
   localparam logic [4:0] OP_SUB    = 5'b00001;
   localparam logic [4:0] OP_MUL    = 5'b00010;
   localparam logic [4:0] OP_QUOT   = 5'b00011;
   localparam logic [4:0] OP_NAND   = 5'b00100;
   localparam logic [4:0] OP_NOR    = 5'b00101;
   localparam logic [4:0] OP_PASSA  = 5'b00110;
   localparam logic [4:0] OP_XOR    = 5'b00111;
   localparam logic [4:0] OP_REM    = 5'b01000;
   localparam logic [4:0] OP_SPINC  = 5'b01001;
   localparam logic [4:0] OP_SPDEC  = 5'b01010;
   localparam logic [4:0] OP_PC     = 5'b01011;
   localparam logic [4:0] OP_PCSHR  = 5'b01100;
   localparam logic [4:0] OP_PCSHRS = 5'b01101;
   localparam logic [4:0] OP_PCINC  = 5'b01110;
   localparam logic [4:0] OP_DIN    = 5'b11111;

   localparam int FLG_Z = 0;
   localparam int FLG_C = 1;
   localparam int FLG_N = 2;

   localparam logic [2:0] FLAGS_RST = 3'b000;

   typedef enum logic {
      DIV_IDLE = 1'b0,
      DIV_RUN  = 1'b1
   } div_state_t;

   // General register i comes out of reset holding i+1 (caller truncates to width).
   function automatic int reg_rst_val(input int idx);
      return idx + 1;
   endfunction

endpackage

// File: rtl/up_divider.sv
// up_divider: restoring divider producing one quotient bit per clock.
//   clk, nRst      clock, async active-low reset
//   start          launch (ignored while busy)
//   dividend       A, sampled on the start edge
//   divisor        B, sampled on the start edge
//   busy           high for exactly DATA_W cycles
//   done           one-cycle pulse on the edge that updates quot/rem
//   quot, rem      results, held between divides
//   dbz            divisor was zero on the last completed divide
//
// state    | meaning
// DIV_IDLE | waiting for start, results stable
// DIV_RUN  | shifting one quotient bit per cycle, cnt counts down to 1
module up_divider
   import up_pkg::*;
#(
   parameter int DATA_W = 8
)(
   input  logic              clk,
   input  logic              nRst,
   input  logic              start,
   input  logic [DATA_W-1:0] dividend,
   input  logic [DATA_W-1:0] divisor,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] quot,
   output logic [DATA_W-1:0] rem,
   output logic              dbz
);

   localparam int CNT_W = $clog2(DATA_W + 1);

   div_state_t        state_q, state_nx;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] q_sh, p_acc, d_lat;
   logic [DATA_W:0]   trial;
   logic              q_bit;
   logic [DATA_W-1:0] p_nx, q_nx;
   logic              load, step, finish;

   // A zero divisor needs no special casing: every trial subtract succeeds,
   // giving an all-ones quotient and the dividend as remainder.
   always_comb begin
      trial = {p_acc, q_sh[DATA_W-1]};
      q_bit = (trial >= {1'b0, d_lat});
      p_nx  = q_bit ? DATA_W'(trial - {1'b0, d_lat}) : trial[DATA_W-1:0];
      q_nx  = {q_sh[DATA_W-2:0], q_bit};
   end

   always_comb begin
      state_nx = state_q;
      load     = 1'b0;
      step     = 1'b0;
      finish   = 1'b0;
      case (state_q)
         DIV_IDLE: begin
            if (start) begin
               load     = 1'b1;
               state_nx = DIV_RUN;
            end
         end
         DIV_RUN: begin
            step = 1'b1;
            if (cnt == CNT_W'(1)) begin
               finish   = 1'b1;
               state_nx = DIV_IDLE;
            end
         end
         default: state_nx = DIV_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) state_q <= DIV_IDLE;
      else       state_q <= state_nx;
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         cnt   <= '0;
         q_sh  <= '0;
         p_acc <= '0;
         d_lat <= '0;
         done  <= 1'b0;
         quot  <= '0;
         rem   <= '0;
         dbz   <= 1'b0;
      end else begin
         done <= finish;
         if (load) begin
            q_sh  <= dividend;
            p_acc <= '0;
            d_lat <= divisor;
            cnt   <= CNT_W'(DATA_W);
         end else if (step) begin
            q_sh  <= q_nx;
            p_acc <= p_nx;
            cnt   <= cnt - CNT_W'(1);
         end
         if (finish) begin
            quot <= q_nx;
            rem  <= p_nx;
            dbz  <= (d_lat == '0);
         end
      end
   end

   assign busy = (state_q == DIV_RUN);

endmodule

// File: rtl/up_datapath_v2.sv
// up_datapath_v2: parametrised datapath between the control FSM and the memory bus.
//   clk, nRst                       clock, async active-low reset
//   data_in                         memory/immediate input
//   op                              result select for data_out
//   ra_sel, rb_sel                  operand A / B register selects
//   wr_sel, wr_src, rb_we           register write: target, source (0 data_in, 1 data_out), enable
//   ir_we, pc_we, sp_we, flags_we   load enables
//   div_start                       launch divide of A by B
//   data_out                        combinational result
//   ir                              instruction slice register
//   flags                           registered {N,C,Z}
//   busy, div_done                  divider running / completion pulse
//   sp_err                          sticky stack wrap error
module up_datapath_v2
   import up_pkg::*;
#(
   parameter  int DATA_W   = 8,
   parameter  int NUM_REGS = 4,
   parameter  int IR_W     = 4,
   localparam int RSEL_W   = $clog2(NUM_REGS)
)(
   input  logic              clk,
   input  logic              nRst,
   input  logic [DATA_W-1:0] data_in,
   input  logic [4:0]        op,
   input  logic [RSEL_W-1:0] ra_sel,
   input  logic [RSEL_W-1:0] rb_sel,
   input  logic [RSEL_W-1:0] wr_sel,
   input  logic              wr_src,
   input  logic              rb_we,
   input  logic              ir_we,
   input  logic              pc_we,
   input  logic              sp_we,
   input  logic              flags_we,
   input  logic              div_start,
   output logic [DATA_W-1:0] data_out,
   output logic [IR_W-1:0]   ir,
   output logic [2:0]        flags,
   output logic              busy,
   output logic              div_done,
   output logic              sp_err
);

   localparam logic [DATA_W-1:0] ALL_ONES = '1;
   localparam int NSLICE = DATA_W / IR_W;
   localparam int SL_W   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   logic [DATA_W-1:0]   r [NUM_REGS];
   logic [DATA_W-1:0]   pc, sp;
   logic [DATA_W-1:0]   a, b, quot, rem, wr_data;
   logic                dbz, carry, sp_wrap;
   logic [DATA_W:0]     sum_x, dif_x;
   logic [2*DATA_W-1:0] prod;
   logic [2:0]          flags_nx;
   logic [SL_W-1:0]     slice_k;
   logic [IR_W-1:0]     ir_nx;

   assign a = r[ra_sel];
   assign b = r[rb_sel];

   assign sum_x = {1'b0, a} + {1'b0, b};
   assign dif_x = {1'b0, a} - {1'b0, b};
   assign prod  = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};

   always_comb begin
      data_out = data_in;
      carry    = 1'b0;
      case (op)
         OP_ADD:    begin data_out = sum_x[DATA_W-1:0]; carry = sum_x[DATA_W]; end
         OP_SUB:    begin data_out = dif_x[DATA_W-1:0]; carry = dif_x[DATA_W]; end
         OP_MUL:    begin data_out = prod[DATA_W-1:0];  carry = (prod[2*DATA_W-1:DATA_W] != '0); end
         OP_QUOT:   begin data_out = quot;              carry = dbz; end
         OP_NAND:   data_out = ~(a & b);
         OP_NOR:    data_out = ~(a | b);
         OP_PASSA:  data_out = a;
         OP_XOR:    data_out = a ^ b;
         OP_REM:    begin data_out = rem;               carry = dbz; end
         OP_SPINC:  data_out = sp + DATA_W'(1);
         OP_SPDEC:  data_out = sp - DATA_W'(1);
         OP_PC:     data_out = pc;
         OP_PCSHR:  data_out = {1'b0, pc[DATA_W-1:1]};
         OP_PCSHRS: data_out = {1'b1, pc[DATA_W-1:1]};
         OP_PCINC:  data_out = pc + DATA_W'(1);
         default:   data_out = data_in;
      endcase
   end

   always_comb begin
      flags_nx        = FLAGS_RST;
      flags_nx[FLG_Z] = (data_out == '0);
      flags_nx[FLG_C] = carry;
      flags_nx[FLG_N] = data_out[DATA_W-1];
   end

   // Low pc bits pick which IR_W-wide slice of data_out lands in ir.
   assign slice_k = (NSLICE > 1) ? pc[SL_W-1:0] : '0;
   assign ir_nx   = IR_W'(data_out >> (slice_k * IR_W));

   assign wr_data = wr_src ? data_out : data_in;

   assign sp_wrap = sp_we && (((op == OP_SPINC) && (sp == ALL_ONES)) ||
                              ((op == OP_SPDEC) && (sp == '0)));

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         for (int i = 0; i < NUM_REGS; i++) r[i] <= DATA_W'(reg_rst_val(i));
      end else if (rb_we) begin
         r[wr_sel] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         pc     <= '0;
         sp     <= ALL_ONES;
         ir     <= '0;
         flags  <= FLAGS_RST;
         sp_err <= 1'b0;
      end else begin
         if (pc_we)    pc    <= data_out;
         if (sp_we)    sp    <= data_out;
         if (ir_we)    ir    <= ir_nx;
         if (flags_we) flags <= flags_nx;
         if (sp_wrap)  sp_err <= 1'b1;
      end
   end

   up_divider #(.DATA_W(DATA_W)) u_div (
      .clk      (clk),
      .nRst     (nRst),
      .start    (div_start),
      .dividend (a),
      .divisor  (b),
      .busy     (busy),
      .done     (div_done),
      .quot     (quot),
      .rem      (rem),
      .dbz      (dbz)
   );

endmodule

// File: tb/tb_up_datapath_v2.sv
module tb_up_datapath_v2;
   import up_pkg::*;

   localparam int DW = 8;
   localparam int NR = 4;
   localparam int IW = 4;
   localparam int RW = 2;

   logic          clk = 1'b0;
   logic          nRst;
   logic [DW-1:0] data_in;
   logic [4:0]    op;
   logic [RW-1:0] ra_sel, rb_sel, wr_sel;
   logic          wr_src, rb_we, ir_we, pc_we, sp_we, flags_we, div_start;
   logic [DW-1:0] data_out;
   logic [IW-1:0] ir;
   logic [2:0]    flags;
   logic          busy, div_done, sp_err;

   always #5 clk = ~clk;

   up_datapath_v2 #(.DATA_W(DW), .NUM_REGS(NR), .IR_W(IW)) dut (
      .clk(clk), .nRst(nRst), .data_in(data_in), .op(op),
      .ra_sel(ra_sel), .rb_sel(rb_sel), .wr_sel(wr_sel), .wr_src(wr_src),
      .rb_we(rb_we), .ir_we(ir_we), .pc_we(pc_we), .sp_we(sp_we),
      .flags_we(flags_we), .div_start(div_start),
      .data_out(data_out), .ir(ir), .flags(flags), .busy(busy),
      .div_done(div_done), .sp_err(sp_err)
   );

   logic [31:0] exp_q [$];
   string       tag_q [$];
   int          n_cmp = 0;
   int          n_mis = 0;

   task automatic expect_v(input string tag, input logic [31:0] v);
      exp_q.push_back(v);
      tag_q.push_back(tag);
   endtask

   task automatic check_v(input logic [31:0] obs);
      logic [31:0] e;
      string       t;
      n_cmp++;
      if (exp_q.size() == 0) begin
         n_mis++;
         $display("FAIL scoreboard_empty observed=0x%0h", obs);
         return;
      end
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
         n_mis++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", t, obs, e);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_reg(input logic [RW-1:0] sel, input logic [DW-1:0] v);
      op = OP_DIN; data_in = v; wr_sel = sel; wr_src = 1'b0; rb_we = 1'b1;
      tick();
      rb_we = 1'b0;
   endtask

   task automatic alu(input string tag, input logic [4:0] o, input logic [RW-1:0] ra,
                      input logic [RW-1:0] rb, input logic [DW-1:0] e);
      op = o; ra_sel = ra; rb_sel = rb;
      #1;
      expect_v(tag, 32'(e));
      check_v(32'(data_out));
   endtask

   task automatic latch_flags(input string tag, input logic [4:0] o, input logic [RW-1:0] ra,
                              input logic [RW-1:0] rb, input logic [2:0] e);
      op = o; ra_sel = ra; rb_sel = rb; flags_we = 1'b1;
      tick();
      flags_we = 1'b0;
      expect_v(tag, 32'(e));
      check_v(32'(flags));
   endtask

   task automatic load_pc(input logic [DW-1:0] v);
      op = OP_DIN; data_in = v; pc_we = 1'b1;
      tick();
      pc_we = 1'b0;
   endtask

   initial begin
      logic got;
      logic seen_done;

      nRst = 1'b0; data_in = '0; op = OP_ADD; ra_sel = '0; rb_sel = '0; wr_sel = '0;
      wr_src = 1'b0; rb_we = 1'b0; ir_we = 1'b0; pc_we = 1'b0; sp_we = 1'b0;
      flags_we = 1'b0; div_start = 1'b0;
      #12;

      // reset state
      expect_v("rst_busy", 0);   check_v(32'(busy));
      expect_v("rst_done", 0);   check_v(32'(div_done));
      expect_v("rst_sperr", 0);  check_v(32'(sp_err));
      expect_v("rst_flags", 0);  check_v(32'(flags));
      expect_v("rst_ir", 0);     check_v(32'(ir));
      alu("rst_r0", OP_PASSA, 2'd0, 2'd0, 8'h01);
      alu("rst_pc", OP_PC, 2'd0, 2'd0, 8'h00);
      alu("rst_sp_inc", OP_SPINC, 2'd0, 2'd0, 8'h00);
      @(posedge clk); #1 nRst = 1'b1;

      alu("add_reset_regs", OP_ADD, 2'd1, 2'd2, 8'h05);
      latch_flags("flags_add5", OP_ADD, 2'd1, 2'd2, 3'b000);

      write_reg(2'd1, 8'hFF);
      write_reg(2'd2, 8'h01);
      alu("add_wrap", OP_ADD, 2'd1, 2'd2, 8'h00);
      latch_flags("flags_add_wrap", OP_ADD, 2'd1, 2'd2, 3'b011);

      write_reg(2'd1, 8'h35);
      write_reg(2'd2, 8'h0F);
      alu("add", OP_ADD, 2'd1, 2'd2, 8'h44);
      alu("sub", OP_SUB, 2'd1, 2'd2, 8'h26);
      alu("mul", OP_MUL, 2'd1, 2'd2, 8'h1B);
      alu("nand", OP_NAND, 2'd1, 2'd2, 8'hFA);
      alu("nor", OP_NOR, 2'd1, 2'd2, 8'hC0);
      alu("xor", OP_XOR, 2'd1, 2'd2, 8'h3A);
      alu("din_default", 5'b10101, 2'd1, 2'd2, 8'h0F);
      latch_flags("flags_mul", OP_MUL, 2'd1, 2'd2, 3'b010);
      latch_flags("flags_sub_borrow", OP_SUB, 2'd2, 2'd1, 3'b110);

      // divide 200 / 7 with a mid-run restart and an operand overwrite
      write_reg(2'd1, 8'd200);
      write_reg(2'd2, 8'd7);
      op = OP_QUOT; ra_sel = 2'd1; rb_sel = 2'd2; div_start = 1'b1;
      tick();
      div_start = 1'b0;
      expect_v("div_busy_c1", 1); check_v(32'(busy));
      for (int c = 2; c <= 8; c++) begin
         if (c == 3) begin
            ra_sel = 2'd2; rb_sel = 2'd1; div_start = 1'b1;
            op = OP_DIN; data_in = 8'd50; wr_sel = 2'd1; wr_src = 1'b0; rb_we = 1'b1;
         end else begin
            div_start = 1'b0; rb_we = 1'b0; op = OP_QUOT;
         end
         tick();
         expect_v("div_busy_run", 1); check_v(32'(busy));
         expect_v("div_done_early", 0); check_v(32'(div_done));
      end
      div_start = 1'b0; rb_we = 1'b0;
      alu("quot_held_while_busy", OP_QUOT, 2'd1, 2'd2, 8'h00);
      tick();
      expect_v("div_busy_fall", 0); check_v(32'(busy));
      expect_v("div_done_pulse", 1); check_v(32'(div_done));
      tick();
      expect_v("div_done_one_cycle", 0); check_v(32'(div_done));
      alu("quot_200_7", OP_QUOT, 2'd1, 2'd2, 8'd28);
      alu("rem_200_7", OP_REM, 2'd1, 2'd2, 8'd4);
      latch_flags("flags_quot_ok", OP_QUOT, 2'd1, 2'd2, 3'b000);
      alu("overwrite_landed", OP_PASSA, 2'd1, 2'd2, 8'd50);

      // divide by zero
      write_reg(2'd2, 8'h00);
      ra_sel = 2'd1; rb_sel = 2'd2; div_start = 1'b1;
      tick();
      div_start = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (div_done) begin got = 1'b1; break; end
      end
      expect_v("dbz_done_seen", 1); check_v(32'(got));
      alu("dbz_quot", OP_QUOT, 2'd1, 2'd2, 8'hFF);
      alu("dbz_rem", OP_REM, 2'd1, 2'd2, 8'd50);
      latch_flags("flags_dbz", OP_QUOT, 2'd1, 2'd2, 3'b110);

      // stack pointer wrap and stickiness
      op = OP_SPINC; sp_we = 1'b1;
      tick();
      sp_we = 1'b0;
      expect_v("sperr_set_inc_wrap", 1); check_v(32'(sp_err));
      alu("sp_after_wrap", OP_SPINC, 2'd0, 2'd0, 8'h01);
      op = OP_SPINC; sp_we = 1'b1;
      tick();
      op = OP_SPDEC;
      tick();
      sp_we = 1'b0;
      expect_v("sperr_sticky", 1); check_v(32'(sp_err));
      alu("sp_dec_at_zero", OP_SPDEC, 2'd0, 2'd0, 8'hFF);

      // instruction slice load
      load_pc(8'h03);
      alu("pc_loaded", OP_PC, 2'd0, 2'd0, 8'h03);
      op = OP_DIN; data_in = 8'hA5; ir_we = 1'b1;
      tick();
      ir_we = 1'b0;
      expect_v("ir_slice1", 32'h0A); check_v(32'(ir));
      load_pc(8'h02);
      op = OP_DIN; data_in = 8'hA5; ir_we = 1'b1;
      tick();
      ir_we = 1'b0;
      expect_v("ir_slice0", 32'h05); check_v(32'(ir));
      alu("pc_shr", OP_PCSHR, 2'd0, 2'd0, 8'h01);
      alu("pc_shr_msb", OP_PCSHRS, 2'd0, 2'd0, 8'h81);
      alu("pc_inc", OP_PCINC, 2'd0, 2'd0, 8'h03);

      // reset in the middle of a divide
      write_reg(2'd2, 8'd3);
      ra_sel = 2'd1; rb_sel = 2'd2; div_start = 1'b1;
      tick();
      div_start = 1'b0;
      tick(); tick(); tick();
      nRst = 1'b0;
      #1;
      expect_v("abort_busy", 0); check_v(32'(busy));
      tick(); tick();
      nRst = 1'b1;
      seen_done = 1'b0;
      for (int k = 0; k < 12; k++) begin
         tick();
         seen_done = seen_done | div_done;
      end
      expect_v("abort_no_done", 0); check_v(32'(seen_done));
      expect_v("abort_sperr", 0);   check_v(32'(sp_err));
      expect_v("abort_flags", 0);   check_v(32'(flags));
      expect_v("abort_ir", 0);      check_v(32'(ir));
      alu("abort_r1", OP_PASSA, 2'd1, 2'd0, 8'h02);
      alu("abort_r3", OP_PASSA, 2'd3, 2'd0, 8'h04);
      alu("abort_quot", OP_QUOT, 2'd1, 2'd2, 8'h00);
      alu("abort_rem", OP_REM, 2'd1, 2'd2, 8'h00);
      alu("abort_pc", OP_PC, 2'd0, 2'd0, 8'h00);
      alu("abort_sp", OP_SPDEC, 2'd0, 2'd0, 8'hFE);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
